// File: rtl/i2s_tx_aes_formatter_pkg.sv
// Shared I2S transmitter definitions: AES3 preambles, channel ids, subframe type and parity helper.
package i2s_tx_defines;

  localparam logic [3:0] PRE_Z = 4'h1;
  localparam logic [3:0] PRE_X = 4'h2;
  localparam logic [3:0] PRE_Y = 4'h3;

  localparam logic [0:0] TID_LEFT  = 1'b0;
  localparam logic [0:0] TID_RIGHT = 1'b1;

  typedef logic [31:0] aes_subframe_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } fmt_state_e;

  // Even parity over bits 4..31: P equals the XOR of the payload bits 4..30.
  function automatic logic aes_parity(input aes_subframe_t sf);
    return ^sf[30:4];
  endfunction

endpackage

// File: rtl/i2s_tx_aes_formatter.sv
// Stereo PCM pair to AES3-style L/R subframe formatter feeding the I2S core's AXI-Stream input.
// Optional build macro I2S_TX_FMT_PARITY_EN fills bit 31 with even parity; otherwise P=0.
module i2s_tx_aes_formatter
  import i2s_tx_defines::*;
#(
  parameter int PCM_WIDTH    = 24,
  parameter int BLOCK_FRAMES = 192,
  parameter int TID_WIDTH    = 3
) (
  input  logic                   s_axis_aud_aclk,
  input  logic                   s_axis_aud_aresetn,
  input  logic                   fmt_en,
  input  logic [2*PCM_WIDTH-1:0] s_pcm_tdata,
  input  logic                   s_pcm_tvalid,
  output logic                   s_pcm_tready,
  output logic [31:0]            m_axis_aud_tdata,
  output logic [TID_WIDTH-1:0]   m_axis_aud_tid,
  output logic                   m_axis_aud_tvalid,
  input  logic                   m_axis_aud_tready,
  output logic [7:0]             frame_cnt
);

  localparam int         PAD_BITS   = 24 - PCM_WIDTH;
  localparam logic [7:0] LAST_FRAME = 8'(BLOCK_FRAMES - 1);

  fmt_state_e             state_r, state_s;
  aes_subframe_t          tdata_r, tdata_s;
  logic [TID_WIDTH-1:0]   tid_r, tid_s;
  logic                   tvalid_r, tvalid_s;
  logic [PCM_WIDTH-1:0]   right_r, right_s;
  logic [7:0]             cnt_r, cnt_s;
  logic [7:0]             cnt_inc_s;
  logic                   pcm_ready_s;
  logic                   accept_s;
  logic                   beat_s;

  function automatic aes_subframe_t build_subframe(input logic [3:0] pre,
                                                   input logic [PCM_WIDTH-1:0] sample);
    aes_subframe_t sf;
    sf = {4'b0000, 24'(sample) << PAD_BITS, pre};
`ifdef I2S_TX_FMT_PARITY_EN
    sf[31] = aes_parity(sf);
`endif
    return sf;
  endfunction

  // A new pair may enter from IDLE, or in RIGHT in the very cycle the right beat leaves.
  assign pcm_ready_s = s_axis_aud_aresetn && fmt_en &&
                       ((state_r == ST_IDLE) || ((state_r == ST_RIGHT) && m_axis_aud_tready));
  assign accept_s    = pcm_ready_s && s_pcm_tvalid;
  assign beat_s      = tvalid_r && m_axis_aud_tready;
  assign cnt_inc_s   = (cnt_r == LAST_FRAME) ? 8'd0 : cnt_r + 8'd1;

  // Next-state, output register and frame counter update logic.
  always_comb begin
    state_s  = state_r;
    tdata_s  = tdata_r;
    tid_s    = tid_r;
    tvalid_s = tvalid_r;
    right_s  = right_r;
    cnt_s    = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s  = ST_LEFT;
          tdata_s  = build_subframe((cnt_r == 8'd0) ? PRE_Z : PRE_X, s_pcm_tdata[PCM_WIDTH-1:0]);
          tid_s    = TID_WIDTH'(TID_LEFT);
          tvalid_s = 1'b1;
          right_s  = s_pcm_tdata[2*PCM_WIDTH-1:PCM_WIDTH];
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LEFT: begin
        if (beat_s) begin
          state_s = ST_RIGHT;
          tdata_s = build_subframe(PRE_Y, right_r);
          tid_s   = TID_WIDTH'(TID_RIGHT);
        end else begin
          state_s = ST_LEFT;
        end
      end
      ST_RIGHT: begin
        if (beat_s && accept_s) begin
          state_s = ST_LEFT;
          cnt_s   = cnt_inc_s;
          tdata_s = build_subframe((cnt_inc_s == 8'd0) ? PRE_Z : PRE_X, s_pcm_tdata[PCM_WIDTH-1:0]);
          tid_s   = TID_WIDTH'(TID_LEFT);
          right_s = s_pcm_tdata[2*PCM_WIDTH-1:PCM_WIDTH];
        end else if (beat_s) begin
          // Underrun or disable: go quiet; a disabled formatter restarts its block at Z.
          state_s  = ST_IDLE;
          tvalid_s = 1'b0;
          cnt_s    = fmt_en ? cnt_inc_s : 8'd0;
        end else begin
          state_s = ST_RIGHT;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        tvalid_s = 1'b0;
      end
    endcase
  end

  // State, pair holding, output and counter registers with synchronous active-low reset.
  always_ff @(posedge s_axis_aud_aclk) begin
    if (!s_axis_aud_aresetn) begin
      state_r  <= ST_IDLE;
      tdata_r  <= 32'h0000_0000;
      tid_r    <= {TID_WIDTH{1'b0}};
      tvalid_r <= 1'b0;
      right_r  <= {PCM_WIDTH{1'b0}};
      cnt_r    <= 8'd0;
    end else begin
      state_r  <= state_s;
      tdata_r  <= tdata_s;
      tid_r    <= tid_s;
      tvalid_r <= tvalid_s;
      right_r  <= right_s;
      cnt_r    <= cnt_s;
    end
  end

  assign s_pcm_tready      = pcm_ready_s;
  assign m_axis_aud_tdata  = tdata_r;
  assign m_axis_aud_tid    = tid_r;
  assign m_axis_aud_tvalid = tvalid_r;
  assign frame_cnt         = cnt_r;

endmodule

// File: tb/tb_i2s_tx_aes_formatter.sv
// Scoreboard bench for i2s_tx_aes_formatter: a 24-bit and a 16-bit instance run side by side.
module tb_i2s_tx_aes_formatter;

  logic        clk = 1'b0;
  logic        aresetn, fmt_en, pcm_valid, m_tready;
  logic [47:0] pcm_data;
  logic [31:0] pcm_data16;
  logic        pcm_ready, pcm_ready16;
  logic [31:0] tdata, tdata16;
  logic [2:0]  tid, tid16;
  logic        tvalid, tvalid16;
  logic [7:0]  fcnt, fcnt16;

  always #5 clk = ~clk;
  assign pcm_data16 = {pcm_data[47:32], pcm_data[23:8]};

  i2s_tx_aes_formatter #(.PCM_WIDTH(24), .BLOCK_FRAMES(192), .TID_WIDTH(3)) dut (
    .s_axis_aud_aclk(clk), .s_axis_aud_aresetn(aresetn), .fmt_en(fmt_en),
    .s_pcm_tdata(pcm_data), .s_pcm_tvalid(pcm_valid), .s_pcm_tready(pcm_ready),
    .m_axis_aud_tdata(tdata), .m_axis_aud_tid(tid), .m_axis_aud_tvalid(tvalid),
    .m_axis_aud_tready(m_tready), .frame_cnt(fcnt));

  i2s_tx_aes_formatter #(.PCM_WIDTH(16), .BLOCK_FRAMES(192), .TID_WIDTH(3)) dut16 (
    .s_axis_aud_aclk(clk), .s_axis_aud_aresetn(aresetn), .fmt_en(fmt_en),
    .s_pcm_tdata(pcm_data16), .s_pcm_tvalid(pcm_valid), .s_pcm_tready(pcm_ready16),
    .m_axis_aud_tdata(tdata16), .m_axis_aud_tid(tid16), .m_axis_aud_tvalid(tvalid16),
    .m_axis_aud_tready(m_tready), .frame_cnt(fcnt16));

  typedef struct {
    logic [31:0] d;
    logic [31:0] d16;
    logic [2:0]  tid;
  } exp_t;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [31:0] el;
    logic [31:0] er;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[4];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] par(input logic [31:0] x);
    logic [31:0] y;
    y = x;
`ifdef I2S_TX_FMT_PARITY_EN
    y[31] = ^x[30:4];
`endif
    return y;
  endfunction

  // 16-bit instance sees only the top 16 sample bits; bits 11:4 are zero padding.
  function automatic logic [31:0] narrow(input logic [31:0] x);
    return par(x & 32'h7FFF_F00F);
  endfunction

  task automatic push_pair(input logic [31:0] el, input logic [31:0] er);
    exp_t e;
    e.d = par(el); e.d16 = narrow(el); e.tid = 3'd0;
    sb.push_back(e);
    e.d = par(er); e.d16 = narrow(er); e.tid = 3'd1;
    sb.push_back(e);
  endtask

  task automatic send_pair(input logic [23:0] l, input logic [23:0] r,
                           input logic [31:0] el, input logic [31:0] er, output int waits);
    logic got;
    got = 1'b0;
    waits = 0;
    pcm_data = {r, l};
    pcm_valid = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (pcm_ready) begin
        got = 1'b1;
        push_pair(el, er);
        chk("ready16", {31'd0, pcm_ready16}, 32'd1);
      end else begin
        waits++;
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL accept_timeout: pair %h/%h never accepted", l, r);
    end
    @(posedge clk); #1;
    pcm_valid = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !tvalid) done = 1'b1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d beats still expected", sb.size());
    end
    @(posedge clk); #1;
  endtask

  // Scoreboard consumer: every output handshake must match the oldest expected beat.
  always @(negedge clk) begin
    if (aresetn && tvalid && m_tready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_beat: got %h with empty scoreboard", tdata);
      end else begin
        mon_e = sb.pop_front();
        chk("beat_tdata", tdata, mon_e.d);
        chk("beat_tid", {29'd0, tid}, {29'd0, mon_e.tid});
        chk("beat_tdata16", tdata16, mon_e.d16);
        chk("beat_tid16", {29'd0, tid16}, {29'd0, mon_e.tid});
        chk("beat_tvalid16", {31'd0, tvalid16}, 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits;
    logic [23:0] l, r;
    logic [3:0] pre;

    tbl[0] = '{l: 24'h123456, r: 24'hABCDEF, el: 32'h0123_4561, er: 32'h0ABC_DEF3};
    tbl[1] = '{l: 24'hFFFFFF, r: 24'h000001, el: 32'h0FFF_FFF2, er: 32'h0000_0013};
    tbl[2] = '{l: 24'h800000, r: 24'h7FFFFF, el: 32'h0800_0002, er: 32'h07FF_FFF3};
    tbl[3] = '{l: 24'h000000, r: 24'hA5A5A5, el: 32'h0000_0002, er: 32'h0A5A_5A53};

    // Reset with a pair offered
    aresetn = 1'b0; fmt_en = 1'b1; pcm_valid = 1'b1; m_tready = 1'b1; pcm_data = 48'hDEAD_BEEF_CAFE;
    repeat (3) begin
      @(negedge clk);
      chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
      chk("rst_tdata", tdata, 32'd0);
      chk("rst_ready", {31'd0, pcm_ready}, 32'd0);
      chk("rst_fcnt", {24'd0, fcnt}, 32'd0);
      chk("rst_ready16", {31'd0, pcm_ready16}, 32'd0);
      chk("rst_tvalid16", {31'd0, tvalid16}, 32'd0);
      chk("rst_fcnt16", {24'd0, fcnt16}, 32'd0);
    end
    @(posedge clk); #1;
    pcm_valid = 1'b0; aresetn = 1'b1;

    // Isolated pairs from the vector table
    for (int i = 0; i < 4; i++) begin
      send_pair(tbl[i].l, tbl[i].r, tbl[i].el, tbl[i].er, waits);
      chk("latency_tvalid", {31'd0, tvalid}, 32'd1);
      drain();
    end
    chk("fcnt_after_table", {24'd0, fcnt}, 32'd4);

    // Block wrap over 193 back-to-back pairs
    aresetn = 1'b0;
    @(posedge clk); #1;
    aresetn = 1'b1;
    for (int i = 0; i < 193; i++) begin
      l = 24'($urandom);
      r = 24'($urandom);
      pre = (i == 0 || i == 192) ? 4'h1 : 4'h2;
      send_pair(l, r, {4'h0, l, pre}, {4'h0, r, 4'h3}, waits);
      if (i > 0) chk("no_bubble_waits", 32'(waits), 32'd1);
      if (i == 191) chk("fcnt_191", {24'd0, fcnt}, 32'd191);
      if (i == 192) chk("fcnt_wrap_0", {24'd0, fcnt}, 32'd0);
    end
    drain();
    chk("fcnt_after_wrap", {24'd0, fcnt}, 32'd1);
    chk("fcnt16_after_wrap", {24'd0, fcnt16}, 32'd1);

    // Backpressure on the left beat
    m_tready = 1'b0;
    send_pair(24'h111111, 24'h222222, 32'h0111_1112, 32'h0222_2223, waits);
    pcm_data = 48'h999999_888888; pcm_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_tvalid", {31'd0, tvalid}, 32'd1);
      chk("bp_tdata", tdata, par(32'h0111_1112));
      chk("bp_tid", {29'd0, tid}, 32'd0);
      chk("bp_ready", {31'd0, pcm_ready}, 32'd0);
    end
    @(posedge clk); #1;
    pcm_valid = 1'b0; m_tready = 1'b1;
    drain();
    chk("fcnt_after_bp", {24'd0, fcnt}, 32'd2);

    // Disable after the left handshake
    send_pair(24'h0F0F0F, 24'h333333, 32'h00F0_F0F2, 32'h0333_3333, waits);
    @(posedge clk); #1;
    fmt_en = 1'b0; pcm_data = 48'h777777_666666; pcm_valid = 1'b1;
    @(negedge clk);
    chk("dis_right_tvalid", {31'd0, tvalid}, 32'd1);
    chk("dis_right_tid", {29'd0, tid}, 32'd1);
    chk("dis_ready", {31'd0, pcm_ready}, 32'd0);
    @(negedge clk);
    chk("dis_idle_tvalid", {31'd0, tvalid}, 32'd0);
    chk("dis_fcnt_clear", {24'd0, fcnt}, 32'd0);
    chk("dis_idle_ready", {31'd0, pcm_ready}, 32'd0);
    @(posedge clk); #1;
    pcm_valid = 1'b0; fmt_en = 1'b1;
    send_pair(24'h444444, 24'h555555, 32'h0444_4441, 32'h0555_5553, waits);
    drain();
    chk("fcnt_after_reenable", {24'd0, fcnt}, 32'd1);

    // 16-bit alignment, then reset while the right beat is stalled
    send_pair(24'h1234AB, 24'h5678CD, 32'h0123_4AB2, 32'h0567_8CD3, waits);
    chk("width16_field", {8'd0, tdata16[27:4]}, 32'h0012_3400);
    @(posedge clk); #1;
    m_tready = 1'b0;
    chk("rst_mid_right_tid", {29'd0, tid}, 32'd1);
    chk("rst_mid_right_valid", {31'd0, tvalid}, 32'd1);
    aresetn = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_tvalid", {31'd0, tvalid}, 32'd0);
    chk("rst_mid_fcnt", {24'd0, fcnt}, 32'd0);
    chk("rst_mid_tdata", tdata, 32'd0);
    chk("rst_mid_tvalid16", {31'd0, tvalid16}, 32'd0);
    chk("rst_mid_pending", 32'(sb.size()), 32'd1);
    sb.delete();
    aresetn = 1'b1; m_tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {31'd0, tvalid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
